// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP pixel packer: FSM state and the
// RGB565 colour-bar palette used by the optional test pattern.
package dvp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        CAPTURE
    } state_t;

    localparam int PIX_W = 16;

    // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [PIX_W-1:0] BAR_RGB565 [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

endpackage

// File: rtl/dvp_byte_pairer.sv
// Pairs consecutive DVP bytes (high byte first) into one pixel word.
// flush drops any stored half pixel and suppresses the strobe.
module dvp_byte_pairer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    href,
    input  logic                    flush,
    input  logic [DATA_WIDTH-1:0]   data,
    output logic                    pix_stb,
    output logic [2*DATA_WIDTH-1:0] pix_word,
    output logic                    odd
);

    logic                  phase;
    logic [DATA_WIDTH-1:0] hi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 1'b0;
            hi    <= '0;
        end else if (flush || !href) begin
            phase <= 1'b0;
        end else begin
            if (!phase)
                hi <= data;
            phase <= ~phase;
        end
    end

    assign pix_stb  = href && phase && !flush;
    assign pix_word = {hi, data};
    assign odd      = phase;

endmodule

// File: rtl/dvp_pixel_packer.sv
// OV5640 DVP front end: skips warm-up frames, packs byte pairs into pixel
// words, clips to the latched resolution and flags line/frame geometry errors.
// Define DVP_PIXEL_PACKER_TEST_PATTERN_EN to replace camera data with colour bars.
module dvp_pixel_packer
    import dvp_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SKIP_FRAMES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    capture_en_i,
    input  logic [DATA_WIDTH-1:0]   cam_half_pixel_i,
    input  logic                    cam_href,
    input  logic                    cam_vsync,
    input  logic [15:0]             resolution_width_i,
    input  logic [15:0]             resolution_depth_i,
    output logic                    wr_pixel_o,
    output logic [2*DATA_WIDTH-1:0] pixel_data_o,
    output logic                    frame_start_o,
    output logic                    frame_done_o,
    output logic                    line_err_o,
    output logic                    frame_err_o,
    output logic [CNT_WIDTH-1:0]    frame_cnt_o
);

    logic [DATA_WIDTH-1:0]   d_r;
    logic                    href_r, href_q, vsync_r, vsync_q;
    logic                    vs_rise, href_fall, mid_abort, aborted;
    logic                    pix_stb, odd, begin_frame, skip_last;
    logic [2*DATA_WIDTH-1:0] pair_word, pix_word;
    logic [CNT_WIDTH-1:0]    pix_cnt, line_cnt, width_l, depth_l, skip_cnt;
    state_t                  state;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            d_r     <= '0;
            href_r  <= 1'b0;
            href_q  <= 1'b0;
            vsync_r <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            d_r     <= cam_half_pixel_i;
            href_r  <= cam_href;
            href_q  <= href_r;
            vsync_r <= cam_vsync;
            vsync_q <= vsync_r;
        end
    end

    assign vs_rise   = vsync_r && !vsync_q;
    assign href_fall = href_q && !href_r;
    assign mid_abort = vs_rise && href_r;
    assign skip_last = (skip_cnt == CNT_WIDTH'(SKIP_FRAMES - 1));

    // Bytes of a line cut short by vsync are discarded until href drops
    dvp_byte_pairer #(.DATA_WIDTH(DATA_WIDTH)) u_pairer (
        .clk      (clk_i),
        .rst      (reset_i),
        .href     (href_r),
        .flush    (mid_abort || aborted),
        .data     (d_r),
        .pix_stb  (pix_stb),
        .pix_word (pair_word),
        .odd      (odd)
    );

`ifdef DVP_PIXEL_PACKER_TEST_PATTERN_EN
    logic [2:0]           bar_idx;
    logic [CNT_WIDTH+2:0] pix_x8;

    // bar = pixel*8/width, computed as a count of threshold crossings
    always_comb begin
        pix_x8  = {pix_cnt, 3'b000};
        bar_idx = '0;
        for (int k = 1; k < 8; k++)
            if (pix_x8 >= (CNT_WIDTH+3)'(k) * {3'b000, width_l})
                bar_idx = 3'(k);
    end
    assign pix_word = (2*DATA_WIDTH)'(BAR_RGB565[bar_idx]);
`else
    assign pix_word = pair_word;
`endif

    always_comb begin
        begin_frame = 1'b0;
        if (vs_rise && capture_en_i) begin
            case (state)
                IDLE:    begin_frame = (SKIP_FRAMES == 0);
                SKIP:    begin_frame = skip_last;
                default: begin_frame = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= IDLE;
            skip_cnt      <= '0;
            width_l       <= '0;
            depth_l       <= '0;
            pix_cnt       <= '0;
            line_cnt      <= '0;
            aborted       <= 1'b0;
            wr_pixel_o    <= 1'b0;
            pixel_data_o  <= '0;
            frame_start_o <= 1'b0;
            frame_done_o  <= 1'b0;
            line_err_o    <= 1'b0;
            frame_err_o   <= 1'b0;
            frame_cnt_o   <= '0;
        end else begin
            wr_pixel_o    <= 1'b0;
            frame_start_o <= 1'b0;
            frame_done_o  <= 1'b0;

            if (mid_abort)
                aborted <= 1'b1;
            else if (href_fall)
                aborted <= 1'b0;

            case (state)
                IDLE: begin
                    if (vs_rise && capture_en_i) begin
                        skip_cnt <= '0;
                        state    <= (SKIP_FRAMES == 0) ? CAPTURE : SKIP;
                    end
                end
                SKIP: begin
                    if (vs_rise) begin
                        skip_cnt <= skip_cnt + 1'b1;
                        if (!capture_en_i)
                            state <= IDLE;
                        else if (skip_last)
                            state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (vs_rise) begin
                        frame_done_o <= 1'b1;
                        frame_cnt_o  <= frame_cnt_o + 1'b1;
                        frame_err_o  <= (line_cnt != depth_l) || href_r;
                        if (!capture_en_i)
                            state <= IDLE;
                    end else begin
                        if (pix_stb) begin
                            if (pix_cnt < width_l && line_cnt < depth_l) begin
                                wr_pixel_o   <= 1'b1;
                                pixel_data_o <= pix_word;
                            end
                            if (pix_cnt != '1)
                                pix_cnt <= pix_cnt + 1'b1;
                        end
                        if (href_fall) begin
                            if (!aborted) begin
                                if (line_cnt != '1)
                                    line_cnt <= line_cnt + 1'b1;
                                if (odd || pix_cnt != width_l)
                                    line_err_o <= 1'b1;
                            end
                            pix_cnt <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (begin_frame) begin
                frame_start_o <= 1'b1;
                width_l       <= CNT_WIDTH'(resolution_width_i);
                depth_l       <= CNT_WIDTH'(resolution_depth_i);
                line_err_o    <= 1'b0;
                line_cnt      <= '0;
                pix_cnt       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dvp_pixel_packer.sv
// Directed bench for dvp_pixel_packer: frame skipping, packing, clipping,
// geometry errors, mid-line vsync, enable drop/re-enable and async reset.
module tb_dvp_pixel_packer;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, href = 1'b0, vsync = 1'b0;
    logic [7:0]  d = '0;
    logic [15:0] width = '0, depth = '0;
    logic        wr, fs, fd, le, fe;
    logic [15:0] data, fcnt;
    int          npass = 0, ntot = 0, n_start = 0, n_done = 0;
    logic [15:0] wq[$], eq[$];

    localparam logic [15:0] BARS [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

    always #5 clk = ~clk;

    dvp_pixel_packer dut (
        .clk_i              (clk),
        .reset_i            (rst),
        .capture_en_i       (en),
        .cam_half_pixel_i   (d),
        .cam_href           (href),
        .cam_vsync          (vsync),
        .resolution_width_i (width),
        .resolution_depth_i (depth),
        .wr_pixel_o         (wr),
        .pixel_data_o       (data),
        .frame_start_o      (fs),
        .frame_done_o       (fd),
        .line_err_o         (le),
        .frame_err_o        (fe),
        .frame_cnt_o        (fcnt)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (wr) wq.push_back(data);
            if (fs) n_start++;
            if (fd) n_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_line(input logic [7:0] b0, input int n);
        href = 1'b1;
        for (int i = 0; i < n; i++) begin
            d = b0 + 8'(i);
            tick();
        end
        href = 1'b0;
        d = '0;
        repeat (3) tick();
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        repeat (2) tick();
        vsync = 1'b0;
        repeat (3) tick();
    endtask

    function automatic logic [15:0] exp_word(input logic [7:0] hi, input logic [7:0] lo,
                                             input int idx, input int w);
`ifdef DVP_PIXEL_PACKER_TEST_PATTERN_EN
        return BARS[(idx * 8) / w];
`else
        return {hi, lo};
`endif
    endfunction

    task automatic exp_line(input logic [7:0] b0, input int npix, input int w);
        for (int i = 0; i < npix; i++)
            eq.push_back(exp_word(b0 + 8'(2*i), b0 + 8'(2*i + 1), i, w));
    endtask

    task automatic cmp_words(input string tag);
        int n;
        chk({tag, "_count"}, wq.size(), eq.size());
        n = (wq.size() < eq.size()) ? wq.size() : eq.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_w%0d", tag, i), wq[i], eq[i]);
        wq.delete();
        eq.delete();
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_wr", wr, 0);
        chk("rst_data", data, 0);
        chk("rst_flags", {fs, fd, le, fe}, 0);
        chk("rst_fcnt", fcnt, 0);
        rst = 1'b0;
        tick();

        // Two warm-up frames produce nothing
        en = 1'b1; width = 16'd4; depth = 16'd2;
        vsync_pulse(); send_line(8'h01, 8); send_line(8'h09, 8);
        vsync_pulse(); send_line(8'h01, 8); send_line(8'h09, 8);
        chk("skip_writes", wq.size(), 0);
        chk("skip_start", n_start, 0);

        // First captured frame
        vsync_pulse();
        chk("cap_start", n_start, 1);
        send_line(8'h01, 8); send_line(8'h09, 8);
        exp_line(8'h01, 4, 4); exp_line(8'h09, 4, 4);
        chk("cap_done_before", n_done, 0);
        vsync_pulse();
        cmp_words("clean");
        chk("clean_done", n_done, 1);
        chk("clean_fcnt", fcnt, 1);
        chk("clean_ferr", fe, 0);

        // Odd-length line, then an over-long line clipped to width
        send_line(8'h21, 9);
        chk("odd_lerr", le, 1);
        send_line(8'h31, 12);
        exp_line(8'h21, 4, 4); exp_line(8'h31, 4, 4);
        vsync_pulse();
        cmp_words("odd");
        chk("odd_lerr_cleared", le, 0);
        chk("odd_ferr", fe, 0);
        chk("odd_fcnt", fcnt, 2);

        // Extra line beyond depth is dropped and flagged
        send_line(8'h41, 8); send_line(8'h51, 8); send_line(8'h61, 8);
        exp_line(8'h41, 4, 4); exp_line(8'h51, 4, 4);
        vsync_pulse();
        cmp_words("deep");
        chk("deep_ferr", fe, 1);
        chk("deep_fcnt", fcnt, 3);

        send_line(8'h71, 8); send_line(8'h81, 8);
        exp_line(8'h71, 4, 4); exp_line(8'h81, 4, 4);
        vsync_pulse();
        cmp_words("clean2");
        chk("clean2_ferr", fe, 0);

        // vsync arrives while href is high
        send_line(8'h91, 8);
        href = 1'b1;
        for (int i = 0; i < 4; i++) begin d = 8'hA1 + 8'(i); tick(); end
        vsync = 1'b1; d = 8'hA5; tick();
        d = 8'hA6; tick();
        href = 1'b0; vsync = 1'b0; d = '0;
        repeat (3) tick();
        exp_line(8'h91, 4, 4); exp_line(8'hA1, 2, 4);
        cmp_words("abort");
        chk("abort_ferr", fe, 1);
        chk("abort_fcnt", fcnt, 5);

        // Aborted line's tail must not count toward the next frame
        send_line(8'hB1, 8); send_line(8'hC1, 8);
        exp_line(8'hB1, 4, 4); exp_line(8'hC1, 4, 4);
        chk("post_abort_lerr", le, 0);
        vsync_pulse();
        cmp_words("post_abort");
        chk("post_abort_ferr", fe, 0);
        chk("post_abort_start", n_start, 7);

        // Enable dropped mid-frame: frame still completes
        send_line(8'hD1, 8);
        en = 1'b0;
        send_line(8'hE1, 8);
        exp_line(8'hD1, 4, 4); exp_line(8'hE1, 4, 4);
        vsync_pulse();
        cmp_words("en_drop");
        chk("en_drop_done", n_done, 7);
        chk("en_drop_start", n_start, 7);
        chk("en_drop_fcnt", fcnt, 7);
        send_line(8'h01, 8); send_line(8'h09, 8);

        // Re-enable repeats the two-frame skip
        en = 1'b1;
        vsync_pulse(); send_line(8'h01, 8); send_line(8'h09, 8);
        vsync_pulse(); send_line(8'h01, 8); send_line(8'h09, 8);
        chk("reen_writes", wq.size(), 0);
        width = 16'd8; depth = 16'd1;
        vsync_pulse();
        chk("reen_start", n_start, 8);
        send_line(8'h01, 16);
        exp_line(8'h01, 8, 8);
        vsync_pulse();
        cmp_words("w8");
        chk("w8_fcnt", fcnt, 8);
        chk("w8_ferr", fe, 0);

        // Async reset mid-line clears outputs without waiting for a clock
        href = 1'b1;
        for (int i = 0; i < 5; i++) begin d = 8'h11 + 8'(i); tick(); end
        #2 rst = 1'b1;
        #1;
        chk("arst_wr", wr, 0);
        chk("arst_data", data, 0);
        chk("arst_fcnt", fcnt, 0);
        tick();
        href = 1'b0; d = '0;
        rst = 1'b0;
        wq.delete();
        tick();
        vsync_pulse(); send_line(8'h01, 8); send_line(8'h09, 8);
        vsync_pulse();
        chk("arst_no_writes", wq.size(), 0);
        chk("arst_fcnt_after", fcnt, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
